// File: rtl/mem_bus_interconnect_if.sv
// Bus bundle between the core data port, the interconnect and its peripherals.
// The interconnect takes the slave modport; the surrounding system (core + peripherals) the master one.
interface mem_bus_interconnect_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_SLV      = 3
);
  logic                        req_valid;
  logic                        req_we;
  logic [ADDR_WIDTH-1:0]       req_addr;
  logic [DATA_WIDTH-1:0]       req_wdata;
  logic                        rsp_ready;
  logic                        rsp_err;
  logic [DATA_WIDTH-1:0]       rsp_rdata;
  logic [N_SLV-1:0]            slv_sel;
  logic                        slv_we;
  logic [ADDR_WIDTH-1:0]       slv_addr;
  logic [DATA_WIDTH-1:0]       slv_wdata;
  logic [N_SLV*DATA_WIDTH-1:0] slv_rdata;
  logic [N_SLV-1:0]            slv_ready;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, slv_rdata, slv_ready,
    input  rsp_ready, rsp_err, rsp_rdata, slv_sel, slv_we, slv_addr, slv_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, slv_rdata, slv_ready,
    output rsp_ready, rsp_err, rsp_rdata, slv_sel, slv_we, slv_addr, slv_wdata
  );
endinterface

// File: rtl/mem_bus_interconnect.sv
// Address-decoding interconnect: routes one core access at a time to one of N_SLV
// base/mask windows, waits for the slave's ready, and answers unmapped or stalled accesses with an error.
module mem_bus_interconnect #(
  parameter int                          DATA_WIDTH = 32,
  parameter int                          ADDR_WIDTH = 32,
  parameter int                          N_SLV      = 3,
  parameter logic [N_SLV*ADDR_WIDTH-1:0] SLV_BASE   = {32'h1001_0010, 32'h1001_0000, 32'h1000_0000},
  parameter logic [N_SLV*ADDR_WIDTH-1:0] SLV_MASK   = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000},
  parameter int                          TIMEOUT    = 16
) (
  input logic                   clk,
  input logic                   n_rst,
  mem_bus_interconnect_if.slave bus
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_off;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_hit;
  logic [IDX_W-1:0]        w_idx;
  logic [ADDR_WIDTH-1:0]   w_off;
  logic                    w_sel_ready;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic                    w_timeout;
  logic [N_SLV-1:0]        w_sel;

  // Scan from the top index down so the lowest matching window is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_off = bus.req_addr & ~SLV_MASK[0 +: ADDR_WIDTH];
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((bus.req_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
        w_off = bus.req_addr & ~SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign w_sel_ready = bus.slv_ready[r_idx];
  assign w_sel_rdata = bus.slv_rdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    w_sel  = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) w_next = w_hit ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        for (int i = 0; i < N_SLV; i++) w_sel[i] = (r_idx == IDX_W'(i));
        if (w_sel_ready || w_timeout) w_next = S_RESP;
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_off   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_idx   <= w_idx;
            r_we    <= bus.req_we;
            r_off   <= w_off;
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            r_err   <= !w_hit;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          // Ready on the last watchdog cycle still completes cleanly.
          if (w_sel_ready) begin
            if (!r_we) r_rdata <= w_sel_rdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_ready = (r_state == S_RESP);
  assign bus.rsp_err   = (r_state == S_RESP) && r_err;
  assign bus.rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;
  assign bus.slv_sel   = w_sel;
  assign bus.slv_we    = (r_state == S_WAIT) && r_we;
  assign bus.slv_addr  = (r_state == S_WAIT) ? r_off : '0;
  assign bus.slv_wdata = (r_state == S_WAIT) ? r_wdata : '0;

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// Directed-vector bench for mem_bus_interconnect, with a transaction-level model
// that predicts every cycle's outputs from the decode windows and latency rules.
module tb_mem_bus_interconnect;

  localparam int TO = 16;

  logic clk;
  logic n_rst;

  mem_bus_interconnect_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_SLV(3)) bus ();

  mem_bus_interconnect #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .N_SLV(3),
    .SLV_BASE({32'h1001_0010, 32'h1001_0000, 32'h1000_0000}),
    .SLV_MASK({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000}),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mBase   [3] = '{32'h1000_0000, 32'h1001_0000, 32'h1001_0010};
  logic [31:0] mMask   [3] = '{32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
  logic [31:0] slvData [3] = '{32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444};

  int checkCount = 0;
  int passCount  = 0;

  // Transaction model: one outstanding access described by its decode and its response cycle.
  bit          active = 1'b0;
  int          cyc    = 0;
  bit          mHit, mWe, mErr;
  int          mIdx, mRespCyc;
  logic [31:0] mAddr, mWdata;

  int          obsRespCyc, obsSelCycles;
  logic [31:0] obsRdata, obsAddr;
  logic        obsErr, obsWe;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic        expReady, expErr, expWe, inWait;
    logic [31:0] expRdata, expAddr, expWdata;
    logic [2:0]  expSel;
    expReady = 1'b0; expErr = 1'b0; expWe = 1'b0; inWait = 1'b0;
    expRdata = '0; expAddr = '0; expWdata = '0; expSel = '0;
    if (active) begin
      inWait   = mHit && (cyc >= 1) && (cyc < mRespCyc);
      expReady = (cyc == mRespCyc);
      expErr   = expReady && mErr;
      if (expReady && !mErr && !mWe) expRdata = slvData[mIdx];
      if (inWait) begin
        expSel   = 3'b001 << mIdx;
        expWe    = mWe;
        expAddr  = mAddr & ~mMask[mIdx];
        expWdata = mWdata;
      end
    end
    checkOutput("rsp_ready", bus.rsp_ready, expReady);
    checkOutput("rsp_err",   bus.rsp_err,   expErr);
    checkOutput("rsp_rdata", bus.rsp_rdata, expRdata);
    checkOutput("slv_sel",   bus.slv_sel,   expSel);
    checkOutput("slv_we",    bus.slv_we,    expWe);
    checkOutput("slv_addr",  bus.slv_addr,  expAddr);
    checkOutput("slv_wdata", bus.slv_wdata, expWdata);
    if (bus.rsp_ready) begin
      obsRespCyc = cyc;
      obsRdata   = bus.rsp_rdata;
      obsErr     = bus.rsp_err;
    end
    if (bus.slv_sel != 3'b000) begin
      obsSelCycles++;
      obsAddr = bus.slv_addr;
      obsWe   = bus.slv_we;
    end
  end

  // One access starting at the current cycle; readyAt<1 means the slave never answers,
  // noise drives ready on the other slaves, abortAt>0 pulls reset in that cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                               input int readyAt, input logic [2:0] noise, input int abortAt);
    int         hitIdx;
    logic [2:0] selMask;
    hitIdx = -1;
    for (int i = 0; i < 3; i++)
      if (hitIdx < 0 && (addr & mMask[i]) == mBase[i]) hitIdx = i;
    mHit   = (hitIdx >= 0);
    mIdx   = mHit ? hitIdx : 0;
    mWe    = we;
    mAddr  = addr;
    mWdata = wdata;
    if (!mHit) begin
      mErr = 1'b1; mRespCyc = 1;
    end else if (readyAt >= 1 && readyAt <= TO) begin
      mErr = 1'b0; mRespCyc = readyAt + 1;
    end else begin
      mErr = 1'b1; mRespCyc = TO + 1;
    end
    selMask = mHit ? (3'b001 << mIdx) : 3'b000;
    obsRespCyc = -1; obsSelCycles = 0; obsRdata = '0; obsAddr = '0; obsErr = 1'b0; obsWe = 1'b0;
    cyc = 0;
    active = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.slv_ready = noise & ~selMask;
    for (int c = 1; c <= mRespCyc + 1; c++) begin
      @(posedge clk); #1;
      cyc = c;
      if (c == abortAt) begin
        n_rst = 1'b0;
        active = 1'b0;
        bus.req_valid = 1'b0;
        bus.slv_ready = '0;
        #1;
        checkOutput("abort_sel",   bus.slv_sel,   3'b000);
        checkOutput("abort_ready", bus.rsp_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        return;
      end
      bus.slv_ready = (noise & ~selMask) | ((c == readyAt) ? selMask : 3'b000);
    end
    active = 1'b0;
    bus.req_valid = 1'b0;
    bus.slv_ready = '0;
  endtask

  task automatic idleCycles(input int n);
    active = 1'b0;
    bus.req_valid = 1'b0;
    bus.slv_ready = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.slv_ready = '0;
    bus.slv_rdata = {slvData[2], slvData[1], slvData[0]};
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", bus.rsp_ready, 1'b0);
    checkOutput("reset_sel",   bus.slv_sel,   3'b000);
    n_rst = 1'b1;
    idleCycles(1);

    $display("[TB] RAM read, zero wait");
    applyStimulus(32'h1000_0040, 1'b0, 32'h0, 1, 3'b000, 0);
    checkOutput("t1_resp_cyc", obsRespCyc, 2);
    checkOutput("t1_rdata",    obsRdata,   32'hDEAD_BEEF);
    checkOutput("t1_err",      obsErr,     1'b0);
    checkOutput("t1_addr",     obsAddr,    32'h40);
    idleCycles(2);

    $display("[TB] UART write, three wait states, RAM ready noise");
    applyStimulus(32'h1001_0004, 1'b1, 32'h55, 4, 3'b101, 0);
    checkOutput("t2_resp_cyc", obsRespCyc,   5);
    checkOutput("t2_sel_cyc",  obsSelCycles, 4);
    checkOutput("t2_we",       obsWe,        1'b1);
    checkOutput("t2_rdata",    obsRdata,     32'h0);
    checkOutput("t2_addr",     obsAddr,      32'h4);
    idleCycles(1);

    $display("[TB] unmapped address");
    applyStimulus(32'h2000_0000, 1'b0, 32'h0, -1, 3'b111, 0);
    checkOutput("t3_resp_cyc", obsRespCyc,   1);
    checkOutput("t3_err",      obsErr,       1'b1);
    checkOutput("t3_sel_cyc",  obsSelCycles, 0);
    idleCycles(1);

    $display("[TB] GPIO timeout");
    applyStimulus(32'h1001_0010, 1'b0, 32'h0, -1, 3'b011, 0);
    checkOutput("t4_resp_cyc", obsRespCyc,   17);
    checkOutput("t4_err",      obsErr,       1'b1);
    checkOutput("t4_sel_cyc",  obsSelCycles, 16);
    checkOutput("t4_rdata",    obsRdata,     32'h0);
    idleCycles(1);

    $display("[TB] ready on final watchdog cycle, then back-to-back write");
    applyStimulus(32'h1001_0018, 1'b0, 32'h0, 16, 3'b000, 0);
    checkOutput("t5_resp_cyc", obsRespCyc, 17);
    checkOutput("t5_err",      obsErr,     1'b0);
    checkOutput("t5_rdata",    obsRdata,   32'h3333_4444);
    checkOutput("t5_addr",     obsAddr,    32'h8);
    applyStimulus(32'h1000_1234, 1'b1, 32'hCAFE_F00D, 2, 3'b000, 0);
    checkOutput("t7_resp_cyc", obsRespCyc, 3);
    checkOutput("t7_addr",     obsAddr,    32'h1234);
    checkOutput("t7_err",      obsErr,     1'b0);
    idleCycles(1);

    $display("[TB] reset during WAIT, then normal access");
    applyStimulus(32'h1000_0100, 1'b0, 32'h0, -1, 3'b000, 3);
    checkOutput("t6_no_resp", obsRespCyc, -1);
    idleCycles(1);
    applyStimulus(32'h1001_0008, 1'b0, 32'h0, 2, 3'b000, 0);
    checkOutput("t6_resp_cyc", obsRespCyc, 3);
    checkOutput("t6_rdata",    obsRdata,   32'h1111_2222);
    checkOutput("t6_err",      obsErr,     1'b0);
    idleCycles(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
